// File: rtl/datapath_sequencer.sv
// Instruction sequencer feeding the integer datapath: accepts instruction (+ optional
// immediate) words, drives the control word for RPT+1 execute cycles, latches C/N/Z.
module datapath_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        In_Valid,
  input  logic [15:0] In_Data,
  output logic        In_Ready,
  input  logic        C_In,
  input  logic        N_In,
  input  logic        Z_In,
  output logic        W_En,
  output logic        S_Sel,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic [3:0]  Alu_Op,
  output logic [15:0] DS,
  output logic        Flag_C,
  output logic        Flag_N,
  output logic        Flag_Z,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned OW = 4;
  localparam int unsigned CW = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IMM  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] op_q, op_d;
  logic [AW-1:0] wadr_q, wadr_d;
  logic [AW-1:0] radr_q, radr_d;
  logic [AW-1:0] sadr_q, sadr_d;
  logic          ssel_q, ssel_d;
  logic [DW-1:0] ds_q, ds_d;
  logic [2:0]    flags_q, flags_d;
  logic          done_q, done_d;
  logic          xfer_c;

  assign In_Ready = reset & ((state_q == S_IDLE) | (state_q == S_IMM));
  assign xfer_c   = In_Valid & In_Ready;

  // Next-state and control-word decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    wadr_d  = wadr_q;
    radr_d  = radr_q;
    sadr_d  = sadr_q;
    ssel_d  = ssel_q;
    ds_d    = ds_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer_c) begin
          op_d    = In_Data[15:12];
          wadr_d  = In_Data[11:9];
          radr_d  = In_Data[8:6];
          sadr_d  = In_Data[5:3];
          ssel_d  = In_Data[2];
          cnt_d   = In_Data[1:0];
          ds_d    = '0;
          state_d = In_Data[2] ? S_IMM : S_EXEC;
        end
      end
      S_IMM: begin
        if (xfer_c) begin
          ds_d    = In_Data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Every execute edge overwrites the flags; the final repeat's value survives.
        flags_d = {C_In, N_In, Z_In};
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      wadr_q  <= '0;
      radr_q  <= '0;
      sadr_q  <= '0;
      ssel_q  <= 1'b0;
      ds_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      wadr_q  <= wadr_d;
      radr_q  <= radr_d;
      sadr_q  <= sadr_d;
      ssel_q  <= ssel_d;
      ds_q    <= ds_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign W_En   = (state_q == S_EXEC);
  assign Busy   = (state_q != S_IDLE);
  assign Done   = done_q;
  assign S_Sel  = ssel_q;
  assign W_Adr  = wadr_q;
  assign R_Adr  = radr_q;
  assign S_Adr  = sadr_q;
  assign Alu_Op = op_q;
  assign DS     = ds_q;
  assign Flag_C = flags_q[2];
  assign Flag_N = flags_q[1];
  assign Flag_Z = flags_q[0];

endmodule
